// File: rtl/core_scheduler.sv
// Instruction-sequencing FSM for a single core: fetch, decode, optional LSU
// handshake, execute and PC update, stopping when a RET opcode retires.
module core_scheduler #(
  parameter int         DATA_WIDTH = 16,
  parameter int         ADDR_WIDTH = 8,
  parameter logic [3:0] RET_OPCODE = 4'b1111,
  parameter logic [3:0] JMP_OPCODE = 4'b0001,
  parameter logic [3:0] LDR_OPCODE = 4'b0111,
  parameter logic [3:0] STR_OPCODE = 4'b1000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic                  mem_read_valid,
  output logic [ADDR_WIDTH-1:0] mem_read_address,
  input  logic                  mem_read_ready,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  input  logic                  lsu_busy,
  output logic                  lsu_req,
  output logic                  reg_write_en,
  output logic [DATA_WIDTH-1:0] instruction,
  output logic [3:0]            opcode,
  output logic [3:0]            dest_reg,
  output logic [3:0]            src_reg,
  output logic [7:0]            immediate,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [2:0]            core_state,
  output logic                  done
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_DECODE  = 3'd2,
    ST_REQUEST = 3'd3,
    ST_WAIT    = 3'd4,
    ST_EXECUTE = 3'd5,
    ST_UPDATE  = 3'd6,
    ST_DONE    = 3'd7
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] instr_q, instr_d;
  logic [3:0]            opcode_q, opcode_d;
  logic [3:0]            dest_q, dest_d;
  logic [3:0]            src_q, src_d;
  logic [7:0]            imm_q, imm_d;

  logic isMemOp;
  logic isNoWriteOp;

  assign isMemOp     = (opcode_q == LDR_OPCODE) || (opcode_q == STR_OPCODE);
  assign isNoWriteOp = (opcode_q == JMP_OPCODE) || (opcode_q == STR_OPCODE) ||
                       (opcode_q == RET_OPCODE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pc_q     <= '0;
      instr_q  <= '0;
      opcode_q <= '0;
      dest_q   <= '0;
      src_q    <= '0;
      imm_q    <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      opcode_q <= opcode_d;
      dest_q   <= dest_d;
      src_q    <= src_d;
      imm_q    <= imm_d;
    end
  end

  // Strobes decode straight from the state register so reset clears them at once.
  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    instr_d        = instr_q;
    opcode_d       = opcode_q;
    dest_d         = dest_q;
    src_d          = src_q;
    imm_d          = imm_q;
    mem_read_valid = 1'b0;
    lsu_req        = 1'b0;
    reg_write_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        mem_read_valid = 1'b1;
        if (mem_read_ready) begin
          instr_d = mem_read_data;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        opcode_d = instr_q[15:12];
        dest_d   = instr_q[11:8];
        src_d    = instr_q[7:4];
        imm_d    = instr_q[7:0];
        state_d  = ST_REQUEST;
      end
      ST_REQUEST: begin
        lsu_req = isMemOp;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (!(isMemOp && lsu_busy)) begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        state_d = ST_UPDATE;
      end
      ST_UPDATE: begin
        reg_write_en = !isNoWriteOp;
        if (opcode_q == RET_OPCODE) begin
          state_d = ST_DONE;
        end else begin
          pc_d    = (opcode_q == JMP_OPCODE) ? ADDR_WIDTH'(imm_q) : pc_q + ADDR_WIDTH'(1);
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        if (!start) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign mem_read_address = pc_q;
  assign instruction      = instr_q;
  assign opcode           = opcode_q;
  assign dest_reg         = dest_q;
  assign src_reg          = src_q;
  assign immediate        = imm_q;
  assign pc               = pc_q;
  assign core_state       = state_q;
  assign done             = (state_q == ST_DONE);

endmodule
